ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage and consumer side of the ID/EX pipeline register.
- Decodes ALUOp/funct into an ALU operation and computes results and the beq branch decision.
- Runs a 32-cycle iterative shift-add multiplier for MUL. During a multiply, stall_o holds IF/ID and ID/EX.
- Registers all results into the EX/MEM outputs.

Parameters:
- MUL_CYCLES, 32, number of multiplier iterations; equals the operand width and is fixed.

Ports:
- clk_i  in  1  clock; all registers update on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  ID/EX holds a real instruction; 0 means bubble
- pc_i  in  32  instruction PC
- Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i  in  1 each  ID/EX control bits
- ALUOp_i  in  2  00 add, 01 branch/sub, 10 R-type, 11 I-type arith
- funct_i  in  10  {funct7, funct3}
- RS1data_i, RS2data_i, imm_i  in  32 each  operands and sign-extended immediate
- RDaddr_i  in  5  destination register
- stall_o  out  1  hold upstream stages (combinational)
- valid_o  out  1  EX/MEM valid
- ALUResult_o  out  32  EX/MEM ALU result
- RS2data_o  out  32  store data
- RDaddr_o  out  5  destination register
- MemRead_o, MemtoReg_o, MemWrite_o, RegWrite_o  out  1 each  EX/MEM control bits
- branch_taken_o  out  1  registered beq taken
- branch_target_o  out  32  registered branch target

Behaviour:
- Reset (rst_i=0, any time, async): all outputs 0, FSM=IDLE, multiplier counter and accumulator cleared. An in-flight multiply is discarded and never written back.
- Operand B = ALUSrc_i ? imm_i : RS2data_i.
- Decode for ALUOp 10 (R-type):
  - {0000000,000} add
  - {0100000,000} sub
  - {0000000,111} and
  - {0000000,110} or
  - {0000000,100} xor
  - {0000000,001} sll by B[4:0]
  - {0100000,101} sra by B[4:0]
  - {0000001,000} mul
  - Any other code → add.
- Decode for other ALUOp values:
  - ALUOp 11: funct3 000 addi; funct3 101 srai by imm[4:0]; others → add.
  - ALUOp 00: add.
  - ALUOp 01: sub.
- Arithmetic is 32-bit, wrapping, no overflow flag. MUL yields the low 32 bits of the unsigned product; this equals the signed low word.
- Branch: branch_taken = valid_i & Branch_i & (RS1data_i == RS2data_i). Target = pc_i + {imm_i[30:0],1'b0}.
- Non-MUL instruction in IDLE: stall_o=0. All EX/MEM outputs register the computed values at the next edge (latency 1).
- Bubble (valid_i=0): register valid_o=0, all control bits 0, branch_taken_o=0. Data outputs are don't-care; drive 0.
- FSM states: IDLE and MUL.
  - IDLE, valid_i & mul decoded: stall_o=1 combinationally. At the edge, latch multiplicand=RS1, multiplier=RS2, acc=0, cnt=0, go to MUL. EX/MEM registers a bubble.
  - MUL, each cycle: if multiplier[0], add multiplicand to acc; multiplicand<<=1; multiplier>>=1; cnt++.
  - MUL, cnt<31: stall_o=1 and EX/MEM registers a bubble.
  - MUL, cnt==31: stall_o=0. EX/MEM registers the final product (last partial sum combined combinationally), valid_o=1, RegWrite_o/RDaddr_o from the held ID/EX inputs. Return to IDLE.
- MUL timing: presented at cycle 0; stall_o high for cycles 0..31; result visible after edge 33.
- While stall_o=1, ID/EX inputs are held stable by upstream. The block uses the latched operands, not the live inputs.
- Mul with valid_i=0 is ignored and does not start the FSM.
- Back-to-back MULs: the second is seen in IDLE on the cycle after completion and starts normally.

Test Plan:
- Reset mid-multiply: start MUL, pull rst_i low at cycle 10 → all outputs 0 immediately, stall_o=0, no writeback after release.
- ADD/SUB: RS1=5, RS2=7, ALUOp=10, funct=0 → ALUResult_o=12 after 1 edge. Same with funct={0100000,000} → 0xFFFFFFFE.
- I-type and shifts: addi RS1=0xFFFFFFFF, imm=1 → 0. srai RS1=0x80000000, imm=4 → 0xF8000000. sll RS2=31 on RS1=1 → 0x80000000.
- MUL: RS1=0x00012345, RS2=0x00000100, rd=9 → stall_o high exactly 32 cycles, then ALUResult_o=0x01234500, valid_o=1, RDaddr_o=9. Signed 0xFFFFFFFD×3 → 0xFFFFFFF7.
- Branch: Branch_i=1, RS1=RS2=4, pc=0x40, imm=8 → branch_taken_o=1, branch_target_o=0x50. Same with RS2=5 → taken=0.
- Bubbles: valid_i=0 with MemWrite_i=1 and mul funct → valid_o=0, MemWrite_o=0, stall_o never asserted. Back-to-back MULs complete 33 cycles apart with correct products.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX to EX/MEM bundle for the execute stage.
// master drives ID/EX fields, slave (ex_stage) drives EX/MEM fields.
interface ex_stage_if;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        Branch_i;
    logic        MemRead_i;
    logic        MemtoReg_i;
    logic        MemWrite_i;
    logic        ALUSrc_i;
    logic        RegWrite_i;
    logic [1:0]  ALUOp_i;
    logic [9:0]  funct_i;
    logic [31:0] RS1data_i;
    logic [31:0] RS2data_i;
    logic [31:0] imm_i;
    logic [4:0]  RDaddr_i;

    logic        stall_o;
    logic        valid_o;
    logic [31:0] ALUResult_o;
    logic [31:0] RS2data_o;
    logic [4:0]  RDaddr_o;
    logic        MemRead_o;
    logic        MemtoReg_o;
    logic        MemWrite_o;
    logic        RegWrite_o;
    logic        branch_taken_o;
    logic [31:0] branch_target_o;

    modport master (
        output valid_i, pc_i, Branch_i, MemRead_i, MemtoReg_i,
               MemWrite_i, ALUSrc_i, RegWrite_i, ALUOp_i, funct_i,
               RS1data_i, RS2data_i, imm_i, RDaddr_i,
        input  stall_o, valid_o, ALUResult_o, RS2data_o, RDaddr_o,
               MemRead_o, MemtoReg_o, MemWrite_o, RegWrite_o,
               branch_taken_o, branch_target_o
    );

    modport slave (
        input  valid_i, pc_i, Branch_i, MemRead_i, MemtoReg_i,
               MemWrite_i, ALUSrc_i, RegWrite_i, ALUOp_i, funct_i,
               RS1data_i, RS2data_i, imm_i, RDaddr_i,
        output stall_o, valid_o, ALUResult_o, RS2data_o, RDaddr_o,
               MemRead_o, MemtoReg_o, MemWrite_o, RegWrite_o,
               branch_taken_o, branch_target_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, beq resolution, iterative shift-add MUL,
// and the EX/MEM output register.
module ex_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    ex_stage_if.slave  bus
);

    typedef enum logic {S_IDLE, S_MUL} state_e;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SLL, OP_SRA, OP_MUL
    } op_e;

    localparam logic [4:0] CNT_LAST = 5'(MUL_CYCLES - 1);

    state_e      state_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;

    logic        valid_q, valid_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic        mr_q, mr_d;
    logic        m2r_q, m2r_d;
    logic        mw_q, mw_d;
    logic        rw_q, rw_d;
    logic        bt_q, bt_d;
    logic [31:0] tgt_q, tgt_d;

    op_e         op;
    logic [4:0]  shamt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu;
    logic [31:0] acc_nx;
    logic [31:0] res;
    logic        r_type;
    logic        i_type;
    logic        mul_start;
    logic        mul_done;
    logic        load;

    assign op_a   = bus.RS1data_i;
    assign op_b   = bus.ALUSrc_i ? bus.imm_i : bus.RS2data_i;
    assign r_type = (bus.ALUOp_i == 2'b10);
    assign i_type = (bus.ALUOp_i == 2'b11);

    always_comb begin
        op    = OP_ADD;
        shamt = op_b[4:0];
        unique case (1'b1)
            r_type && bus.funct_i == {7'b0100000, 3'b000}:
                op = OP_SUB;
            r_type && bus.funct_i == {7'b0000000, 3'b111}:
                op = OP_AND;
            r_type && bus.funct_i == {7'b0000000, 3'b110}:
                op = OP_OR;
            r_type && bus.funct_i == {7'b0000000, 3'b100}:
                op = OP_XOR;
            r_type && bus.funct_i == {7'b0000000, 3'b001}:
                op = OP_SLL;
            r_type && bus.funct_i == {7'b0100000, 3'b101}:
                op = OP_SRA;
            r_type && bus.funct_i == {7'b0000001, 3'b000}:
                op = OP_MUL;
            i_type && bus.funct_i[2:0] == 3'b101: begin
                op    = OP_SRA;
                shamt = bus.imm_i[4:0];
            end
            bus.ALUOp_i == 2'b01:
                op = OP_SUB;
            default: op = OP_ADD;
        endcase
    end

    always_comb begin
        alu = '0;
        unique case (op)
            OP_ADD:  alu = op_a + op_b;
            OP_SUB:  alu = op_a - op_b;
            OP_AND:  alu = op_a & op_b;
            OP_OR:   alu = op_a | op_b;
            OP_XOR:  alu = op_a ^ op_b;
            OP_SLL:  alu = op_a << shamt;
            OP_SRA:  alu = $unsigned($signed(op_a) >>> shamt);
            OP_MUL:  alu = '0;
            default: alu = '0;
        endcase
    end

    // Last partial sum folds in here so the product lands with the final step.
    assign acc_nx    = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    assign mul_start = (state_q == S_IDLE) && bus.valid_i
                       && (op == OP_MUL);
    assign mul_done  = (state_q == S_MUL) && (cnt_q == CNT_LAST);
    assign load      = ((state_q == S_IDLE) && bus.valid_i && !mul_start)
                       || mul_done;
    assign res       = mul_done ? acc_nx : alu;

    assign bus.stall_o = rst_i
                         && (mul_start
                             || ((state_q == S_MUL) && !mul_done));

    always_comb begin
        valid_d = load;
        alu_d   = load ? res : 32'd0;
        rs2_d   = load ? bus.RS2data_i : 32'd0;
        rd_d    = load ? bus.RDaddr_i : 5'd0;
        mr_d    = load & bus.MemRead_i;
        m2r_d   = load & bus.MemtoReg_i;
        mw_d    = load & bus.MemWrite_i;
        rw_d    = load & bus.RegWrite_i;
        bt_d    = load & bus.valid_i & bus.Branch_i
                  & (bus.RS1data_i == bus.RS2data_i);
        tgt_d   = load ? bus.pc_i + {bus.imm_i[30:0], 1'b0} : 32'd0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            alu_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            mr_q     <= 1'b0;
            m2r_q    <= 1'b0;
            mw_q     <= 1'b0;
            rw_q     <= 1'b0;
            bt_q     <= 1'b0;
            tgt_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mul_start) begin
                        mcand_q  <= bus.RS1data_i;
                        mplier_q <= bus.RS2data_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (mul_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            valid_q <= valid_d;
            alu_q   <= alu_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            mr_q    <= mr_d;
            m2r_q   <= m2r_d;
            mw_q    <= mw_d;
            rw_q    <= rw_d;
            bt_q    <= bt_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bus.valid_o         = valid_q;
    assign bus.ALUResult_o     = alu_q;
    assign bus.RS2data_o       = rs2_q;
    assign bus.RDaddr_o        = rd_q;
    assign bus.MemRead_o       = mr_q;
    assign bus.MemtoReg_o      = m2r_q;
    assign bus.MemWrite_o      = mw_q;
    assign bus.RegWrite_o      = rw_q;
    assign bus.branch_taken_o  = bt_q;
    assign bus.branch_target_o = tgt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed instruction stream, cycle model,
// literal expectations and a mid-multiply reset.
module tb_ex_stage;

    logic clk;
    logic rst_n;

    ex_stage_if bus();

    ex_stage #(.MUL_CYCLES(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        br, mr, m2r, mw, src, rw;
        logic [1:0]  op;
        logic [9:0]  f;
        logic [31:0] a, b, imm;
        logic [4:0]  rd;
        logic        chk;
        logic [31:0] ea;
        logic        ebt;
        logic [31:0] etgt;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] alu, rs2;
        logic [4:0]  rd;
        logic        mr, m2r, mw, rw, bt;
        logic [31:0] tgt;
    } out_t;

    int tests = 0;
    int fails = 0;

    vec_t vecs[$];
    vec_t bub;
    out_t zero_o;

    function automatic vec_t mk(
        logic v, logic [31:0] pc, logic br, logic mr, logic m2r,
        logic mw, logic src, logic rw, logic [1:0] op, logic [9:0] f,
        logic [31:0] a, logic [31:0] b, logic [31:0] imm,
        logic [4:0] rd, logic chk, logic [31:0] ea, logic ebt,
        logic [31:0] etgt);
        vec_t x;
        x.v = v; x.pc = pc; x.br = br; x.mr = mr; x.m2r = m2r;
        x.mw = mw; x.src = src; x.rw = rw; x.op = op; x.f = f;
        x.a = a; x.b = b; x.imm = imm; x.rd = rd; x.chk = chk;
        x.ea = ea; x.ebt = ebt; x.etgt = etgt;
        return x;
    endfunction

    function automatic logic is_mul(vec_t x);
        return x.op == 2'b10 && x.f == 10'b0000001000;
    endfunction

    // Plain-arithmetic reading of the instruction semantics.
    function automatic logic [31:0] model_alu(vec_t x);
        logic [31:0] b;
        b = x.src ? x.imm : x.b;
        case (x.op)
            2'b00: return x.a + b;
            2'b01: return x.a - b;
            2'b11: begin
                if (x.f[2:0] == 3'b101)
                    return $unsigned($signed(x.a) >>> x.imm[4:0]);
                return x.a + b;
            end
            default: begin
                case (x.f)
                    10'b0100000000: return x.a - b;
                    10'b0000000111: return x.a & b;
                    10'b0000000110: return x.a | b;
                    10'b0000000100: return x.a ^ b;
                    10'b0000000001: return x.a << b[4:0];
                    10'b0100000101:
                        return $unsigned($signed(x.a) >>> b[4:0]);
                    10'b0000001000: return x.a * x.b;
                    default: return x.a + b;
                endcase
            end
        endcase
    endfunction

    function automatic out_t writeback(vec_t x, logic [31:0] r);
        out_t o;
        o = zero_o;
        if (x.v) begin
            o.v   = 1'b1;
            o.alu = r;
            o.rs2 = x.b;
            o.rd  = x.rd;
            o.mr  = x.mr;
            o.m2r = x.m2r;
            o.mw  = x.mw;
            o.rw  = x.rw;
            o.bt  = x.br && (x.a == x.b);
            o.tgt = x.pc + (x.imm << 1);
        end
        return o;
    endfunction

    task automatic drive(vec_t x);
        bus.valid_i    = x.v;
        bus.pc_i       = x.pc;
        bus.Branch_i   = x.br;
        bus.MemRead_i  = x.mr;
        bus.MemtoReg_i = x.m2r;
        bus.MemWrite_i = x.mw;
        bus.ALUSrc_i   = x.src;
        bus.RegWrite_i = x.rw;
        bus.ALUOp_i    = x.op;
        bus.funct_i    = x.f;
        bus.RS1data_i  = x.a;
        bus.RS2data_i  = x.b;
        bus.imm_i      = x.imm;
        bus.RDaddr_i   = x.rd;
    endtask

    task automatic cmp_out(string nm, out_t e);
        out_t a;
        a.v   = bus.valid_o;
        a.alu = bus.ALUResult_o;
        a.rs2 = bus.RS2data_o;
        a.rd  = bus.RDaddr_o;
        a.mr  = bus.MemRead_o;
        a.m2r = bus.MemtoReg_o;
        a.mw  = bus.MemWrite_o;
        a.rw  = bus.RegWrite_o;
        a.bt  = bus.branch_taken_o;
        a.tgt = bus.branch_target_o;
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s @%0t: got v=%b alu=%h rs2=%h rd=%0d mr=%b m2r=%b mw=%b rw=%b bt=%b tgt=%h; want v=%b alu=%h rs2=%h rd=%0d mr=%b m2r=%b mw=%b rw=%b bt=%b tgt=%h",
                     nm, $time, a.v, a.alu, a.rs2, a.rd, a.mr, a.m2r,
                     a.mw, a.rw, a.bt, a.tgt, e.v, e.alu, e.rs2, e.rd,
                     e.mr, e.m2r, e.mw, e.rw, e.bt, e.tgt);
        end
    endtask

    task automatic cmp(string nm, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
        end
    endtask

    initial begin
        out_t        exp_o;
        int          tag, idx, left, drained, stall_run, cyc;
        logic        es;
        logic [31:0] prod;
        vec_t        cur;
        int          mul_done_cyc[$];

        zero_o = '{v: 0, alu: 0, rs2: 0, rd: 0, mr: 0, m2r: 0,
                   mw: 0, rw: 0, bt: 0, tgt: 0};
        bub = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 10'd0, 0, 0, 0, 0,
                 0, 0, 0, 0);

        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 10'b0000000000,
            32'd5, 32'd7, 0, 5'd1, 1, 32'd12, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 10'b0100000000,
            32'd5, 32'd7, 0, 5'd2, 1, 32'hFFFFFFFE, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 2'b11, 10'b0000000000,
            32'hFFFFFFFF, 32'd0, 32'd1, 5'd3, 1, 32'h0, 0, 32'h2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 2'b11, 10'b0100000101,
            32'h80000000, 32'd0, 32'd4, 5'd4, 1, 32'hF8000000, 0, 32'h8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 10'b0000000001,
            32'd1, 32'd31, 0, 5'd5, 1, 32'h80000000, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 10'b0000000111,
            32'hF0F0, 32'hFF00, 0, 5'd6, 1, 32'hF000, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 10'b0000000110,
            32'hF0F0, 32'hFF00, 0, 5'd7, 1, 32'hFFF0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 10'b0000000100,
            32'hF0F0, 32'hFF00, 0, 5'd8, 1, 32'h0FF0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h40, 1, 0, 0, 0, 0, 0, 2'b01, 10'd0,
            32'd4, 32'd4, 32'd8, 5'd0, 1, 32'h0, 1, 32'h50));
        vecs.push_back(mk(1, 32'h40, 1, 0, 0, 0, 0, 0, 2'b01, 10'd0,
            32'd4, 32'd5, 32'd8, 5'd0, 1, 32'hFFFFFFFF, 0, 32'h50));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 2'b10, 10'b0000001000,
            32'd3, 32'd3, 0, 5'd11, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 10'b0000001000,
            32'h00012345, 32'h100, 0, 5'd9, 1, 32'h01234500, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 10'b0000001000,
            32'hFFFFFFFD, 32'd3, 0, 5'd10, 1, 32'hFFFFFFF7, 0, 32'h0));
        vecs.push_back(mk(1, 32'h10, 0, 1, 1, 0, 1, 1, 2'b00, 10'd0,
            32'h100, 32'd0, 32'hFFFFFFFC, 5'd12, 1, 32'hFC, 0, 32'h8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 2'b00, 10'd0,
            32'h200, 32'hDEAD, 32'd8, 5'd0, 1, 32'h208, 0, 32'h10));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 10'b1111111111,
            32'd2, 32'd3, 0, 5'd13, 1, 32'd5, 0, 32'h0));

        rst_n = 1'b0;
        drive(bub);
        repeat (2) @(negedge clk);
        cmp_out("reset_state", zero_o);
        cmp("reset_stall", {31'd0, bus.stall_o}, 32'd0);
        rst_n = 1'b1;

        exp_o = zero_o; tag = -1; idx = 0; left = 0;
        drained = 0; stall_run = 0; prod = 0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            cmp_out("exmem", exp_o);
            if (tag >= 0 && vecs[tag].chk) begin
                cmp($sformatf("lit_alu[%0d]", tag),
                    bus.ALUResult_o, vecs[tag].ea);
                cmp($sformatf("lit_bt[%0d]", tag),
                    {31'd0, bus.branch_taken_o}, {31'd0, vecs[tag].ebt});
                cmp($sformatf("lit_tgt[%0d]", tag),
                    bus.branch_target_o, vecs[tag].etgt);
            end
            if (idx >= vecs.size() && left == 0) begin
                if (drained > 0) break;
                drained++;
            end
            cur = (idx < vecs.size()) ? vecs[idx] : bub;
            drive(cur);
            #1;
            if (left == 0) begin
                if (cur.v && is_mul(cur)) begin
                    es = 1'b1; left = 32; prod = model_alu(cur);
                    exp_o = zero_o; tag = -1;
                end else begin
                    es = 1'b0;
                    exp_o = writeback(cur, model_alu(cur));
                    tag = (idx < vecs.size()) ? idx : -1;
                    if (idx < vecs.size()) idx++;
                end
            end else if (left > 1) begin
                es = 1'b1; left--; exp_o = zero_o; tag = -1;
            end else begin
                es = 1'b0; left = 0;
                exp_o = writeback(cur, prod);
                tag = idx; idx++;
                mul_done_cyc.push_back(cyc);
            end
            cmp("stall", {31'd0, bus.stall_o}, {31'd0, es});
            if (bus.stall_o) begin
                stall_run++;
            end else if (stall_run > 0) begin
                cmp("stall_len", stall_run, 32);
                stall_run = 0;
            end
        end
        if (cyc >= 3000) begin
            tests++; fails++;
            $display("FAIL timeout: got %0d cycles want < 3000", cyc);
        end
        tests++;
        if (mul_done_cyc.size() != 2) begin
            fails++;
            $display("FAIL mul_count: got %0d want 2", mul_done_cyc.size());
        end else if (mul_done_cyc[1] - mul_done_cyc[0] != 33) begin
            fails++;
            $display("FAIL mul_spacing: got %0d want 33",
                     mul_done_cyc[1] - mul_done_cyc[0]);
        end

        drive(vecs[11]);
        repeat (10) @(negedge clk);
        cmp("pre_reset_stall", {31'd0, bus.stall_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        cmp_out("async_reset", zero_o);
        cmp("async_reset_stall", {31'd0, bus.stall_o}, 32'd0);
        @(negedge clk);
        drive(bub);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cmp("post_reset_valid", {31'd0, bus.valid_o}, 32'd0);
            cmp("post_reset_stall", {31'd0, bus.stall_o}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
